// File: rtl/count_watch.sv
// Watches an upstream counter for wrap, threshold match and stall conditions,
// queueing each detected event in a small show-ahead FIFO with sticky overflow.
module count_watch #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int STALL_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count_in,
  input  logic             count_en,
  input  logic [WIDTH-1:0] thresh,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_code,
  output logic [WIDTH-1:0] evt_value,
  output logic             overflow,
  input  logic             clr_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = WIDTH + 2;
  localparam logic [7:0]       LIMIT = 8'(STALL_LIMIT);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_WRAP  = 2'b01;
  localparam logic [1:0] CODE_MATCH = 2'b10;
  localparam logic [1:0] CODE_STALL = 2'b11;

  logic [WIDTH-1:0] prev_q, prev_d;
  logic             primed_q, primed_d;
  logic [7:0]       stall_q, stall_d;
  logic             overflow_q, overflow_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];

  logic             changed;
  logic             wrap_hit, match_hit, stall_hit;
  logic             push, pop, full, push_ok, drop;
  logic [1:0]       push_code;
  logic [ENT_W-1:0] head;

  always_comb begin
    prev_d   = count_in;
    primed_d = 1'b1;
    changed  = (count_in != prev_q);

    if (count_en && !changed) begin
      stall_d = (stall_q == LIMIT) ? LIMIT : stall_q + 8'd1;
    end else begin
      stall_d = 8'd0;
    end

    // STALL only on the transition into the limit, so a held stall fires once
    wrap_hit  = primed_q && (prev_q == {WIDTH{1'b1}}) && (count_in == '0);
    match_hit = primed_q && (count_in == thresh) && changed;
    stall_hit = primed_q && (stall_q != LIMIT) && (stall_d == LIMIT);

    push_code = CODE_NONE;
    if (wrap_hit) begin
      push_code = CODE_WRAP;
    end else if (match_hit) begin
      push_code = CODE_MATCH;
    end else if (stall_hit) begin
      push_code = CODE_STALL;
    end
    push = (push_code != CODE_NONE);

    pop     = (cnt_q != '0) && evt_ready;
    full    = (cnt_q == FULL);
    push_ok = push && (!full || pop);
    drop    = push && full && !pop;

    mem_d = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = {push_code, count_in};
    end

    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // a drop in the same cycle as a clear keeps the flag set
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q     <= '0;
      primed_q   <= 1'b0;
      stall_q    <= 8'd0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      prev_q     <= prev_d;
      primed_q   <= primed_d;
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // storage needs no reset; outputs are masked while the FIFO is empty
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head      = mem_q[rd_ptr_q];
  assign evt_valid = (cnt_q != '0);
  assign evt_code  = evt_valid ? head[ENT_W-1:WIDTH] : CODE_NONE;
  assign evt_value = evt_valid ? head[WIDTH-1:0] : '0;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_count_watch.sv
// Randomized and directed bench for count_watch, compared every cycle against
// a queue-based behavioural model of the event rules.
module tb_count_watch;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int LIMIT = 16;
  localparam int MAXV  = 255;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] count_in;
  logic             count_en;
  logic [WIDTH-1:0] thresh;
  logic             evt_valid;
  logic             evt_ready;
  logic [1:0]       evt_code;
  logic [WIDTH-1:0] evt_value;
  logic             overflow;
  logic             clr_overflow;

  int checks = 0;
  int errors = 0;

  // model state: pending entries, last sample, primed flag, enabled-hold run length, sticky flag
  int q_code[$];
  int q_val[$];
  int m_prev;
  int m_primed;
  int m_run;
  int m_ovf;

  always #5 clk = ~clk;

  count_watch #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STALL_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .count_in     (count_in),
    .count_en     (count_en),
    .thresh       (thresh),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_code     (evt_code),
    .evt_value    (evt_value),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    q_code.delete();
    q_val.delete();
    m_prev   = 0;
    m_primed = 0;
    m_run    = 0;
    m_ovf    = 0;
  endtask

  // Drive one cycle of inputs, compare outputs with the model, then advance both across the edge.
  task automatic applyStimulus(input logic r, input int cin, input logic en, input int th,
                               input logic rdy, input logic clr);
    int  code;
    int  old_run;
    bit  wrap, match, stall, pop, drop;
    rst          = r;
    count_in     = cin[WIDTH-1:0];
    count_en     = en;
    thresh       = th[WIDTH-1:0];
    evt_ready    = rdy;
    clr_overflow = clr;

    checkOutput("evt_valid", {31'd0, evt_valid}, (q_code.size() > 0) ? 32'd1 : 32'd0);
    checkOutput("evt_code", {30'd0, evt_code}, (q_code.size() > 0) ? q_code[0] : 0);
    checkOutput("evt_value", {24'd0, evt_value}, (q_val.size() > 0) ? q_val[0] : 0);
    checkOutput("overflow", {31'd0, overflow}, m_ovf);

    if (r) begin
      modelReset();
    end else begin
      pop     = (q_code.size() > 0) && rdy;
      wrap    = m_primed != 0 && m_prev == MAXV && cin == 0;
      match   = m_primed != 0 && cin == th && cin != m_prev;
      old_run = m_run;
      if (en && cin == m_prev) m_run = (m_run < LIMIT) ? m_run + 1 : LIMIT;
      else m_run = 0;
      stall = m_primed != 0 && old_run < LIMIT && m_run == LIMIT;
      code  = wrap ? 1 : match ? 2 : stall ? 3 : 0;
      if (pop) begin
        void'(q_code.pop_front());
        void'(q_val.pop_front());
      end
      drop = 0;
      if (code != 0) begin
        if (q_code.size() < DEPTH) begin
          q_code.push_back(code);
          q_val.push_back(cin);
        end else begin
          drop = 1;
        end
      end
      if (drop) m_ovf = 1;
      else if (clr) m_ovf = 0;
      m_prev   = cin;
      m_primed = 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cin, th;
    bit en;
    rst = 1'b1; count_in = '0; count_en = 1'b0; thresh = '0;
    evt_ready = 1'b0; clr_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();

    // reset state, then count 0..7 with thresh 5: single MATCH
    for (int i = 0; i <= 7; i++) applyStimulus(0, i, 1, 5, 1, 0);
    applyStimulus(0, 7, 0, 5, 1, 0);

    // 254,255,0 with thresh 0: WRAP wins over MATCH
    applyStimulus(0, 254, 1, 0, 1, 0);
    applyStimulus(0, 255, 1, 0, 1, 0);
    applyStimulus(0, 0, 1, 0, 1, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 1, 0);

    // enabled hold at 9 stalls once; disabled hold does not
    for (int i = 0; i < 20; i++) applyStimulus(0, 9, 1, 100, 1, 0);
    applyStimulus(0, 3, 0, 100, 1, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 9, 0, 100, 1, 0);

    // five matches with no consumer: four kept, overflow set, drain in order
    for (int i = 10; i <= 14; i++) applyStimulus(0, i, 0, i, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 14, 0, 14, 1, 0);

    // full FIFO push+pop together, then clear coincident with a drop
    applyStimulus(0, 14, 0, 14, 1, 1);
    for (int i = 20; i <= 23; i++) applyStimulus(0, i, 0, i, 0, 0);
    applyStimulus(0, 24, 0, 24, 1, 0);
    applyStimulus(0, 24, 0, 24, 0, 0);
    applyStimulus(0, 25, 0, 25, 0, 1);
    applyStimulus(0, 25, 0, 25, 0, 0);
    applyStimulus(0, 25, 0, 25, 0, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 25, 0, 25, 1, 0);

    // three queued, reset pulse, then 0 after a prior 255 must not wrap
    for (int i = 30; i <= 32; i++) applyStimulus(0, i, 0, i, 0, 0);
    applyStimulus(0, 255, 0, 7, 0, 0);
    applyStimulus(1, 255, 0, 7, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 7, 1, 0);

    // randomized traffic biased toward increments, holds and wrap boundaries
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin cin = (m_prev + 1) % 256; en = 1; end
        4, 5, 6:    begin cin = m_prev; en = ($urandom_range(0, 5) != 0); end
        7:          begin cin = ($urandom_range(0, 1) != 0) ? 255 : 0; en = $urandom_range(0, 1); end
        default:    begin cin = $urandom_range(0, 255); en = $urandom_range(0, 1); end
      endcase
      case ($urandom_range(0, 3))
        0:       th = cin;
        1:       th = (m_prev + 1) % 256;
        2:       th = 0;
        default: th = $urandom_range(0, 255);
      endcase
      if ($urandom_range(0, 39) == 0) begin
        for (int k = 0; k < 18; k++) applyStimulus(0, m_prev, 1, th, $urandom_range(0, 1), 0);
      end
      applyStimulus($urandom_range(0, 249) == 0, cin, en, th,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/count_watch.md
COUNT_WATCH -- requirements
Module: count_watch

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the monitored count.
REQ-002 Parameter DEPTH, default 4: event FIFO entries; power of two, at least 2.
REQ-003 Parameter STALL_LIMIT, default 16: consecutive unchanged enabled samples that trigger a STALL event; range 2..255.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 count_in  input  WIDTH  count value from the upstream counter, sampled every cycle.
REQ-007 count_en  input  1  enable currently driving the upstream counter; high means an increment is expected.
REQ-008 thresh  input  WIDTH  match threshold, sampled every cycle.
REQ-009 evt_valid  output  1  FIFO head entry is available.
REQ-010 evt_ready  input  1  consumer accepts the head entry this cycle.
REQ-011 evt_code  output  2  head entry type: 01 WRAP, 10 MATCH, 11 STALL; 00 when empty.
REQ-012 evt_value  output  WIDTH  count_in value captured with the head entry; 0 when empty.
REQ-013 overflow  output  1  sticky flag: an event was dropped because the FIFO was full.
REQ-014 clr_overflow  input  1  clears overflow.

Function
REQ-015 prev_q (WIDTH bits) and primed_q (1 bit) register count_in each cycle; primed_q sets on the first edge after reset.
REQ-016 Event detection uses only count_in and prev_q; no event is generated while primed_q is 0.
REQ-017 WRAP fires when prev_q equals all-ones and count_in equals 0.
REQ-018 MATCH fires when count_in equals thresh and count_in differs from prev_q, so it fires once per arrival, not while holding.
REQ-019 The stall counter increments when count_en is 1 and count_in equals prev_q, saturating at STALL_LIMIT.
REQ-020 The stall counter clears to 0 when count_in differs from prev_q or count_en is 0.
REQ-021 STALL fires once, on the cycle the stall counter reaches STALL_LIMIT; it rearms only after the counter clears.
REQ-022 At most one event is pushed per cycle, priority WRAP > MATCH > STALL; lower-priority coincident events are discarded without setting overflow.
REQ-023 A push writes {code, count_in} into the FIFO at the detecting edge; evt_valid rises the cycle after that edge when the FIFO was empty (1-cycle latency).
REQ-024 The FIFO is show-ahead: evt_code and evt_value present the head entry while evt_valid is 1.
REQ-025 A pop occurs when evt_valid and evt_ready are both 1; evt_ready while empty has no effect.
REQ-026 Push while not full: accepted. Push and pop in the same cycle while full: both occur, occupancy stays DEPTH, no drop.
REQ-027 Push while full with no pop: the entry is dropped, overflow sets to 1, and FIFO contents are unchanged.
REQ-028 clr_overflow clears overflow next cycle; a drop in the same cycle as clr_overflow leaves overflow at 1 (set wins).
REQ-029 evt_valid and evt_code are always consistent: evt_valid equals 1 exactly when occupancy is nonzero.

Reset
REQ-030 While rst is high at an edge: FIFO empties, prev_q=0, primed_q=0, stall counter=0, overflow=0.
REQ-031 Outputs after reset: evt_valid=0, evt_code=00, evt_value=0, overflow=0.
REQ-032 Reset mid-operation discards all queued events.
REQ-033 After reset the first sample only primes prev_q; no event can fire on it, including count_in=0 after a prior 255.

Verification
REQ-034 Reset, thresh=5, count_en=1, count_in 0,1,2,...,7, evt_ready=1 -> single MATCH with evt_value=5, evt_valid high one cycle after count_in=5 is sampled.
REQ-035 count_in 254,255,0 with thresh=0, evt_ready=1 -> single WRAP entry with evt_value=0; no MATCH entry (WRAP priority).
REQ-036 count_en=1, count_in held at 9 for 20 cycles (STALL_LIMIT=16) -> exactly one STALL with evt_value=9; count_en=0 for the same hold -> no event.
REQ-037 evt_ready=0, five MATCH events generated (thresh changed each time) -> four entries queued, overflow=1; drain with evt_ready=1 -> first four values in order, then evt_valid=0.
REQ-038 FIFO full, push and pop in the same cycle -> occupancy stays 4, overflow stays 0; then clr_overflow coincident with a drop -> overflow remains 1.
REQ-039 Three events queued, rst pulsed for 1 cycle -> evt_valid=0 next cycle; first sample after release is count_in=0 following prior 255 -> no WRAP.
